// File: rtl/imem_fetch_ctrl_if.sv
// rtl/imem_fetch_ctrl_if.sv - fetch controller control, memory and decode-side bus
//
// Purpose: bundles the fetch controller's control inputs, its instruction
//          memory port and its decode-side valid/ready port.
// Signals:
//   en, redirect_valid, redirect_pc  control into the controller
//   imem_addr / imem_instr           combinational instruction memory port
//   out_valid / out_ready            decode handshake
//   out_instr / out_pc               queue head payload
// Modports:
//   master  the fetch controller
//   slave   the environment (memory, decode, branch unit)
interface imem_fetch_ctrl_if;
   logic        en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   modport master (
      input  en, redirect_valid, redirect_pc, imem_instr, out_ready,
      output imem_addr, out_valid, out_instr, out_pc
   );

   modport slave (
      output en, redirect_valid, redirect_pc, imem_instr, out_ready,
      input  imem_addr, out_valid, out_instr, out_pc
   );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch sequencer with prefetch queue
//
// Purpose: owns the fetch PC, drives the combinational instruction memory,
//          captures {pc, instr} into a DEPTH-entry queue and presents the
//          head to decode. A redirect flushes the queue and reloads the PC.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      imem_fetch_ctrl_if.master (control, memory port, decode port)
//   q_count  current queue occupancy (0..DEPTH)
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4,
   localparam int         CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   imem_fetch_ctrl_if.master    bus,
   output logic [CNT_W-1:0]     q_count
);

   localparam int               PTR_W       = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
   localparam logic [31:0]      RESET_PC_AL = {RESET_PC[31:2], 2'b00};

   logic [31:0]      fetch_pc;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [31:0]      q_pc    [DEPTH];
   logic [31:0]      q_instr [DEPTH];

   logic head_valid;
   logic push;
   logic pop;

   // Head is hidden during a redirect so decode can never take a word
   // from the path being flushed.
   assign head_valid = (count != '0) & ~bus.redirect_valid;
   assign pop        = head_valid & bus.out_ready;
   // A pop in the same cycle frees the slot, so a full queue still streams.
   assign push       = bus.en & ~bus.redirect_valid & ((count < FULL_CNT) | pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC_AL;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_pc[i]    <= '0;
            q_instr[i] <= '0;
         end
      end else if (bus.redirect_valid) begin
         fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            q_pc[tail]    <= fetch_pc;
            q_instr[tail] <= bus.imem_instr;
            tail          <= tail + PTR_W'(1);
            fetch_pc      <= fetch_pc + 32'd4;
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         if (push & ~pop) begin
            count <= count + CNT_W'(1);
         end else if (pop & ~push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   assign bus.imem_addr = fetch_pc;
   assign bus.out_valid = head_valid;
   assign bus.out_instr = q_instr[head];
   assign bus.out_pc    = q_pc[head];
   assign q_count       = count;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - scoreboard bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk;
   logic             rst_n;
   logic [CNT_W-1:0] q_count;

   imem_fetch_ctrl_if bus ();

   imem_fetch_ctrl #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (DEPTH)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus.master),
      .q_count (q_count)
   );

   // Instruction memory: mem[i] = 32'h1000_0000 + i, word index addr[9:2].
   assign bus.imem_instr = 32'h1000_0000 + {24'h0, bus.imem_addr[9:2]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [63:0] sb [$];
   logic [31:0] delivered [$];
   logic [31:0] model_pc;
   logic        obs_valid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      return 32'h1000_0000 + ((pc >> 2) & 32'hFF);
   endfunction

   // One clock of stimulus; expected output derived from the scoreboard.
   task automatic cycle(input logic e, input logic r, input logic rv, input logic [31:0] rpc);
      logic exp_valid;
      logic do_pop;
      logic do_push;
      bus.en             = e;
      bus.out_ready      = r;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      #2;
      exp_valid = (sb.size() != 0) && !rv;
      obs_valid = bus.out_valid;
      check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      check("q_count", 32'(q_count), 32'(sb.size()));
      check("imem_addr", bus.imem_addr, model_pc);
      do_pop = exp_valid && r;
      if (do_pop) begin
         check("out_pc", bus.out_pc, sb[0][63:32]);
         check("out_instr", bus.out_instr, sb[0][31:0]);
         delivered.push_back(bus.out_pc);
      end
      do_push = e && !rv && ((sb.size() < DEPTH) || do_pop);
      @(posedge clk);
      #1;
      if (rv) begin
         sb.delete();
         model_pc = {rpc[31:2], 2'b00};
      end else begin
         if (do_pop) void'(sb.pop_front());
         if (do_push) begin
            sb.push_back({model_pc, mem_word(model_pc)});
            model_pc = model_pc + 32'd4;
         end
      end
   endtask

   initial begin
      int d;
      rst_n              = 1'b0;
      bus.en             = 1'b0;
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      model_pc           = 32'h0;
      #3;
      check("rst_valid", 32'(bus.out_valid), 32'h0);
      check("rst_count", 32'(q_count), 32'h0);
      check("rst_addr", bus.imem_addr, 32'h0);
      check("rst_pc", bus.out_pc, 32'h0);
      check("rst_instr", bus.out_instr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Streaming: one word per clock from the cycle after the first fetch.
      repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("stream_n", 32'(delivered.size()), 32'd7);
      check("stream_first", delivered[0], 32'h0);
      check("stream_last", delivered[6], 32'h18);

      // Backpressure from a clean queue at PC 0.
      cycle(1'b1, 1'b1, 1'b1, 32'h0);
      repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("bp_count", 32'(q_count), 32'd4);
      check("bp_pc", bus.imem_addr, 32'h10);

      // Full with simultaneous push and pop.
      d = delivered.size();
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         check("full_count", 32'(q_count), 32'd4);
      end
      for (int k = 0; k < 5; k++) check("bp_order", delivered[d + k], 32'(k * 4));
      check("full_pc", bus.imem_addr, 32'h24);

      // Redirect with three entries queued.
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("pre_redir_count", 32'(q_count), 32'd3);
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0043);
      check("redir_valid", 32'(obs_valid), 32'h0);
      check("redir_count", 32'(q_count), 32'h0);
      check("redir_addr", bus.imem_addr, 32'h40);
      d = delivered.size();
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("redir_bubble", 32'(delivered.size()), 32'(d));
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("redir_first", delivered[d], 32'h40);

      // PC wrap.
      cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
      d = delivered.size();
      repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("wrap0", delivered[d],     32'hFFFF_FFF8);
      check("wrap1", delivered[d + 1], 32'hFFFF_FFFC);
      check("wrap2", delivered[d + 2], 32'h0000_0000);
      check("wrap3", delivered[d + 3], 32'h0000_0004);

      // Asynchronous reset mid-stream.
      cycle(1'b1, 1'b1, 1'b1, 32'h100);
      repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("pre_rst_count", 32'(q_count), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
      check("mid_rst_count", 32'(q_count), 32'h0);
      check("mid_rst_addr", bus.imem_addr, 32'h0);
      sb.delete();
      delivered.delete();
      model_pc = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("post_rst_n", 32'(delivered.size()), 32'd2);
      check("post_rst_pc", delivered[0], 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
